// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu: MIPS load/store unit mastering an Avalon-MM bus, with optional CPU big-endian byte swap.
// States: IDLE (accept request) | BUS (strobe held until !waitrequest or timeout) | RESP (one-cycle result).
module mips_bus_lsu #(
    parameter bit          BIG_ENDIAN     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    output logic        busy
);
    localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  stall_q;
    logic              read_q;
    logic              write_q;
    logic [31:0]       address_q;
    logic [31:0]       writedata_q;
    logic [3:0]        byteenable_q;
    logic              resp_valid_q;
    logic              resp_error_q;
    logic [31:0]       resp_rdata_q;

    logic              req_word;
    logic              req_half;
    logic              req_load;
    logic              misalign_d;
    logic [15:0]       half_wr;
    logic [3:0]        byteenable_d;
    logic [31:0]       writedata_d;

    logic [7:0]        rd_byte;
    logic [15:0]       rd_half_lanes;
    logic [15:0]       rd_half;
    logic [31:0]       rd_word;
    logic [31:0]       rdata_d;

    // Store side: map CPU-order data onto bus lanes at accept time.
    always_comb begin
        req_word     = (req_op == OP_LW) || (req_op == OP_SW);
        req_half     = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
        req_load     = (req_op <= OP_LBU);
        misalign_d   = (req_word && (req_addr[1:0] != 2'b00)) || (req_half && req_addr[0]);
        half_wr      = BIG_ENDIAN ? {req_wdata[7:0], req_wdata[15:8]} : req_wdata[15:0];
        byteenable_d = 4'b0000;
        writedata_d  = 32'h0;
        if (req_word) begin
            byteenable_d = 4'b1111;
            writedata_d  = BIG_ENDIAN ? {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]}
                                      : req_wdata;
        end else if (req_half) begin
            byteenable_d = req_addr[1] ? 4'b1100 : 4'b0011;
            writedata_d  = req_addr[1] ? {half_wr, 16'h0} : {16'h0, half_wr};
        end else begin
            byteenable_d = 4'b0001 << req_addr[1:0];
            writedata_d  = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
        end
    end

    // Load side: pick lanes from readdata, undo byte order, then extend.
    always_comb begin
        rd_byte       = readdata[{off_q, 3'b000} +: 8];
        rd_half_lanes = off_q[1] ? readdata[31:16] : readdata[15:0];
        rd_half       = BIG_ENDIAN ? {rd_half_lanes[7:0], rd_half_lanes[15:8]} : rd_half_lanes;
        rd_word       = BIG_ENDIAN ? {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]}
                                   : readdata;
        case (op_q)
            OP_LW:   rdata_d = rd_word;
            OP_LH:   rdata_d = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  rdata_d = {16'h0, rd_half};
            OP_LB:   rdata_d = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  rdata_d = {24'h0, rd_byte};
            default: rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_LW;
            off_q        <= 2'b00;
            stall_q      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'h0;
            writedata_q  <= 32'h0;
            byteenable_q <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    if (req_valid) begin
                        op_q  <= req_op;
                        off_q <= req_addr[1:0];
                        if (misalign_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                        end else begin
                            state_q      <= BUS;
                            stall_q      <= '0;
                            read_q       <= req_load;
                            write_q      <= !req_load;
                            address_q    <= {req_addr[31:2], 2'b00};
                            byteenable_q <= byteenable_d;
                            writedata_q  <= writedata_d;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest || ((TIMEOUT_CYCLES > 0) && (stall_q == STALL_LAST))) begin
                        state_q      <= RESP;
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        address_q    <= 32'h0;
                        writedata_q  <= 32'h0;
                        byteenable_q <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= waitrequest;
                        resp_rdata_q <= (!waitrequest && read_q) ? rdata_d : 32'h0;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE) && !reset;
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign read       = read_q;
    assign write      = write_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
endmodule
